// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encodings and sensor-level constants for the parking gate
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_IN_A       = 3'd1,
    ST_IN_AB      = 3'd2,
    ST_IN_B       = 3'd3,
    ST_OUT_B      = 3'd4,
    ST_OUT_AB     = 3'd5,
    ST_OUT_A      = 3'd6,
    ST_WAIT_CLEAR = 3'd7
  } state_e;

  // Debounced sensor pair packed as {A, B}, A being the outer beam.
  typedef enum logic [1:0] {
    SNS_CLEAR = 2'b00,
    SNS_B     = 2'b01,
    SNS_A     = 2'b10,
    SNS_AB    = 2'b11
  } sensor_e;

  function automatic logic is_passage(input state_e s);
    return (s != ST_IDLE) && (s != ST_WAIT_CLEAR);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchroniser followed by a stability counter
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Any sample equal to the accepted level restarts the run of differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - single-lane parking gate: direction FSM, occupancy, gate and LED bar
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS       = 20,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a,
  input  logic                 b,
  output logic [CNT_W-1:0]     occupancy,
  output logic [NUM_SLOTS-1:0] led_slot,
  output logic                 full,
  output logic                 empty,
  output logic                 gate_open,
  output logic                 entry_pulse,
  output logic                 exit_pulse,
  output logic                 reject_pulse,
  output logic                 fault_pulse
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(NUM_SLOTS);

  logic a_db;
  logic b_db;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (a),
    .level_o (a_db)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (b),
    .level_o (b_db)
  );

  sensor_e sns;
  assign sns = sensor_e'({a_db, b_db});

  state_e           state_q;
  state_e           state_d;
  logic [TO_W-1:0]  to_cnt_q;
  logic [TO_W-1:0]  to_cnt_d;
  logic [CNT_W-1:0] occ_q;
  logic             gate_q;
  logic             entry_q;
  logic             exit_q;
  logic             reject_q;
  logic             fault_q;
  logic             inc_d;
  logic             dec_d;
  logic             reject_d;
  logic             fault_d;
  logic             full_w;
  logic             empty_w;

  assign full_w  = (occ_q == OCC_MAX);
  assign empty_w = (occ_q == '0);

  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    reject_d = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (sns)
          SNS_A: begin
            if (full_w) begin
              reject_d = 1'b1;
              state_d  = ST_WAIT_CLEAR;
            end else begin
              state_d  = ST_IN_A;
            end
          end
          SNS_B: begin
            if (empty_w) begin
              fault_d = 1'b1;
              state_d = ST_WAIT_CLEAR;
            end else begin
              state_d = ST_OUT_B;
            end
          end
          SNS_AB: begin
            fault_d = 1'b1;
            state_d = ST_WAIT_CLEAR;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_IN_A: begin
        if (sns == SNS_AB)         state_d = ST_IN_AB;
        else if (sns == SNS_CLEAR) state_d = ST_IDLE;
      end
      ST_IN_AB: begin
        if (sns == SNS_B)          state_d = ST_IN_B;
        else if (sns == SNS_A)     state_d = ST_IN_A;
      end
      ST_IN_B: begin
        if (sns == SNS_CLEAR) begin
          state_d = ST_IDLE;
          inc_d   = !full_w;
        end else if (sns == SNS_AB) begin
          state_d = ST_IN_AB;
        end
      end
      ST_OUT_B: begin
        if (sns == SNS_AB)         state_d = ST_OUT_AB;
        else if (sns == SNS_CLEAR) state_d = ST_IDLE;
      end
      ST_OUT_AB: begin
        if (sns == SNS_A)          state_d = ST_OUT_A;
        else if (sns == SNS_B)     state_d = ST_OUT_B;
      end
      ST_OUT_A: begin
        if (sns == SNS_CLEAR) begin
          state_d = ST_IDLE;
          dec_d   = !empty_w;
        end else if (sns == SNS_AB) begin
          state_d = ST_OUT_AB;
        end
      end
      ST_WAIT_CLEAR: begin
        if (sns == SNS_CLEAR)      state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A legal move always wins; the timeout only runs while a passage state is held.
    if (is_passage(state_q) && (state_d == state_q)) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = ST_WAIT_CLEAR;
        fault_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      occ_q    <= '0;
      gate_q   <= 1'b0;
      entry_q  <= 1'b0;
      exit_q   <= 1'b0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (inc_d && !full_w) begin
        occ_q <= occ_q + 1'b1;
      end else if (dec_d && !empty_w) begin
        occ_q <= occ_q - 1'b1;
      end
      gate_q   <= is_passage(state_q);
      entry_q  <= inc_d;
      exit_q   <= dec_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
    end
  end

  logic [NUM_SLOTS-1:0] led_w;

  always_comb begin
    led_w = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      led_w[i] = (CNT_W'(i) < occ_q);
    end
  end

  assign occupancy    = occ_q;
  assign led_slot     = led_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign gate_open    = gate_q;
  assign entry_pulse  = entry_q;
  assign exit_pulse   = exit_q;
  assign reject_pulse = reject_q;
  assign fault_pulse  = fault_q;

endmodule
